mux2_rr_arbiter: RTL

Upstream feeder stage for the 2:1 mux (mux21) datapath. Arbitrates between two valid/ready input channels with round-robin priority and registers the winning word. Drives the mux select `sel` alongside the registered data. Provides a single registered output with valid/ready, 1-cycle latency and full throughput.

---
 rtl/mux2_rr_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin feeder for the mux21 datapath.
// Two valid/ready input channels compete for one registered output slot.
// The winner's word is registered onto o_data together with the mux select
// `sel` (0 = channel 1, 1 = channel 2). The output slot reloads in the same
// cycle it drains, giving 1-cycle latency and 1 word/cycle throughput.
//
// Optional feature: define MUX_GRANT_COUNT_EN to add the saturating per-channel
// accept counters i1_grants / i2_grants (CNT_W bits each).
//
// Handshake semantics (all channels): a word moves on a rising clk edge when
// valid and ready are both high in the preceding cycle. A producer holds valid
// and data stable until accepted and never derives valid from ready; ready
// here may depend combinationally on valid.
//
// dbg_state exposes the FSM state (0 = EMPTY, 1 = HOLD1, 2 = HOLD2).
module mux2_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i1_data,
  input  logic             i1_valid,
  output logic             i1_ready,
  input  logic [WIDTH-1:0] i2_data,
  input  logic             i2_valid,
  output logic             i2_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             sel,
`ifdef MUX_GRANT_COUNT_EN
  output logic [CNT_W-1:0] i1_grants,
  output logic [CNT_W-1:0] i2_grants,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD1 = 2'd1,
    HOLD2 = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] data_next;
  logic             sel_next;
  // Last-grant pointer in sel encoding: 0 = channel 1, 1 = channel 2.
  // Resets to 1 so channel 1 wins the first contention.
  logic             last_ptr, last_next;
  logic             load;
  logic             grant1, grant2;
  logic             acc1, acc2;

  // Grant selection and ready generation; readies are forced low in reset.
  always_comb begin
    grant1 = 1'b0;
    grant2 = 1'b0;
    if (i1_valid && i2_valid) begin
      grant1 = last_ptr;
      grant2 = ~last_ptr;
    end else begin
      grant1 = i1_valid;
      grant2 = i2_valid;
    end
    load     = (state == EMPTY) || o_ready;
    i1_ready = rst_n && load && grant1;
    i2_ready = rst_n && load && grant2;
    acc1     = i1_valid && i1_ready;
    acc2     = i2_valid && i2_ready;
  end

  // Next-state, next output word/select and pointer update.
  always_comb begin
    state_next = state;
    data_next  = o_data;
    sel_next   = sel;
    last_next  = last_ptr;
    if (acc1) begin
      state_next = HOLD1;
      data_next  = i1_data;
      sel_next   = 1'b0;
      last_next  = 1'b0;
    end else if (acc2) begin
      state_next = HOLD2;
      data_next  = i2_data;
      sel_next   = 1'b1;
      last_next  = 1'b1;
    end else if ((state != EMPTY) && o_ready) begin
      state_next = EMPTY;
    end
  end

  // State, held word, select and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      o_data   <= '0;
      sel      <= 1'b0;
      last_ptr <= 1'b1;
    end else begin
      state    <= state_next;
      o_data   <= data_next;
      sel      <= sel_next;
      last_ptr <= last_next;
    end
  end

  assign o_valid   = (state != EMPTY);
  assign dbg_state = state;

`ifdef MUX_GRANT_COUNT_EN
  // Saturating accept counters, one per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_grants <= '0;
      i2_grants <= '0;
    end else begin
      if (acc1 && (i1_grants != {CNT_W{1'b1}})) i1_grants <= i1_grants + 1'b1;
      if (acc2 && (i2_grants != {CNT_W{1'b1}})) i2_grants <= i2_grants + 1'b1;
    end
  end
`endif

endmodule
